// File: rtl/can_frame_sequencer_pkg.sv
// Shared types and constants for the CAN capture channel frame sequencer.
package ch_pkg;

  typedef enum logic [2:0] {
    S_SUBRST = 3'd0,
    S_IDLE   = 3'd1,
    S_ARMED  = 3'd2,
    S_HEADER = 3'd3,
    S_BODY   = 3'd4,
    S_TAIL   = 3'd5
  } seq_state_t;

  localparam logic       RECESSIVE = 1'b1;
  localparam logic       DOMINANT  = 1'b0;
  localparam logic [2:0] STUFF_RUN = 3'd5;

  // Destuffed bits between the end of the header and the end of the CRC.
  // The DLC is clamped so that codes 9..15 still mean an 8-byte payload.
  function automatic logic [6:0] body_target(input logic [3:0] dlc,
                                             input int max_bytes,
                                             input int crc_bits);
    int n;
    n = (int'(dlc) > max_bytes) ? max_bytes : int'(dlc);
    return 7'(n * 8 + crc_bits);
  endfunction

endpackage

// File: rtl/can_frame_sequencer_if.sv
// Signal bundle between the bit-sampling front end / size detector and the
// frame sequencer. The sequencer uses the slave view.
interface can_frame_sequencer_if;
  logic       enable;
  logic       dIn;
  logic       samplePulse;
  logic       rateSelector;
  logic       sdComplete;
  logic [3:0] sdMsgSize;
  logic       sdResetN;
  logic       sdEnable;
  logic       frameActive;
  logic [3:0] dlcLatched;
  logic       frameDone;
  logic       timeoutErr;
  logic       stuffErr;
  logic [2:0] stateDbg;

  modport slave (
    input  enable, dIn, samplePulse, rateSelector, sdComplete, sdMsgSize,
    output sdResetN, sdEnable, frameActive, dlcLatched, frameDone,
           timeoutErr, stuffErr, stateDbg
  );

  modport master (
    output enable, dIn, samplePulse, rateSelector, sdComplete, sdMsgSize,
    input  sdResetN, sdEnable, frameActive, dlcLatched, frameDone,
           timeoutErr, stuffErr, stateDbg
  );
endinterface

// File: rtl/can_frame_sequencer_voter.sv
// Turns sample strobes into qualified bits: one bit per strobe, or one
// majority-voted bit per three strobes when rateSel is high.
module sample_voter (
  input  logic clk,
  input  logic resetN,
  input  logic clr,
  input  logic samplePulse,
  input  logic rateSel,
  input  logic dIn,
  output logic bitValid,
  output logic bitVal
);

  logic [1:0] phase_q, phase_d;
  logic [1:0] smp_q, smp_d;
  logic       valid_q, valid_d;
  logic       val_q, val_d;
  logic       maj;

  assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & dIn) | (smp_q[1] & dIn);

  // Next-state: collect the first two samples, vote on the third.
  always_comb begin
    phase_d = phase_q;
    smp_d   = smp_q;
    valid_d = 1'b0;
    val_d   = val_q;
    if (clr) begin
      phase_d = 2'd0;
    end else if (samplePulse) begin
      if (!rateSel) begin
        valid_d = 1'b1;
        val_d   = dIn;
      end else if (phase_q == 2'd2) begin
        valid_d = 1'b1;
        val_d   = maj;
        phase_d = 2'd0;
      end else begin
        smp_d[phase_q[0]] = dIn;
        phase_d           = phase_q + 2'd1;
      end
    end
  end

  // Registered outputs give the one-cycle delay after the qualifying strobe.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      phase_q <= 2'd0;
      smp_q   <= 2'd0;
      valid_q <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      smp_q   <= smp_d;
      valid_q <= valid_d;
      val_q   <= val_d;
    end
  end

  assign bitValid = valid_q;
  assign bitVal   = val_q;

endmodule

// File: rtl/can_frame_sequencer.sv
// Frame-level controller for the CAN capture channel: idle/SOF detection,
// size-detector sequencing, destuffed body counting and raw tail counting.
//
// state    | meaning
// S_SUBRST | size detector held in reset between frames
// S_IDLE   | counting recessive bits to qualify bus idle
// S_ARMED  | bus idle seen, waiting for a dominant SOF
// S_HEADER | size detector running, waiting for sdComplete
// S_BODY   | counting destuffed payload + CRC bits
// S_TAIL   | counting raw delimiter/ACK/EOF bits, stuffing ignored
module can_frame_sequencer
  import ch_pkg::*;
#(
  parameter int IDLE_BITS        = 11,
  parameter int HDR_TIMEOUT_BITS = 40,
  parameter int CRC_BITS         = 15,
  parameter int TAIL_BITS        = 10,
  parameter int SUB_RST_CYC      = 2,
  parameter int MAX_DATA_BYTES   = 8
) (
  input logic                  clk,
  input logic                  resetN,
  can_frame_sequencer_if.slave bus
);

  localparam logic [3:0] IDLE_N   = 4'(IDLE_BITS);
  localparam logic [5:0] HDR_N    = 6'(HDR_TIMEOUT_BITS);
  localparam logic [3:0] TAIL_N   = 4'(TAIL_BITS);
  localparam logic [2:0] SUB_LAST = 3'(SUB_RST_CYC - 1);

  seq_state_t state_q, state_d;
  logic [2:0] sub_cnt_q, sub_cnt_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic [5:0] hdr_cnt_q, hdr_cnt_d;
  logic [6:0] body_cnt_q, body_cnt_d;
  logic [6:0] body_tgt_q, body_tgt_d;
  logic [3:0] tail_cnt_q, tail_cnt_d;
  logic [2:0] run_len_q, run_len_d;
  logic       prev_bit_q, prev_bit_d;
  logic       rate_sel_q, rate_sel_d;
  logic [3:0] dlc_q, dlc_d;
  logic       done_q, done_d;
  logic       tmo_q, tmo_d;
  logic       serr_q, serr_d;

  logic bit_valid, bit_val;
  logic is_stuff, stuff_viol, counted;
  logic [2:0] run_nxt;

  sample_voter u_voter (
    .clk         (clk),
    .resetN      (resetN),
    .clr         (state_q == S_SUBRST),
    .samplePulse (bus.samplePulse),
    .rateSel     (rate_sel_q),
    .dIn         (bus.dIn),
    .bitValid    (bit_valid),
    .bitVal      (bit_val)
  );

  // A bit following a run of five is a stuff bit: it must differ from the
  // run, is not counted, but starts the next run.
  assign is_stuff   = (run_len_q == STUFF_RUN);
  assign stuff_viol = bit_valid && is_stuff && (bit_val == prev_bit_q);
  assign counted    = bit_valid && !is_stuff;
  assign run_nxt    = (!is_stuff && bit_val == prev_bit_q) ? run_len_q + 3'd1 : 3'd1;

  // Next-state logic for the sequencer FSM, counters and pulses.
  always_comb begin
    state_d    = state_q;
    sub_cnt_d  = 3'd0;
    idle_cnt_d = idle_cnt_q;
    hdr_cnt_d  = hdr_cnt_q;
    body_cnt_d = body_cnt_q;
    body_tgt_d = body_tgt_q;
    tail_cnt_d = tail_cnt_q;
    run_len_d  = run_len_q;
    prev_bit_d = prev_bit_q;
    rate_sel_d = rate_sel_q;
    dlc_d      = dlc_q;
    done_d     = 1'b0;
    tmo_d      = 1'b0;
    serr_d     = 1'b0;

    if (!bus.enable) begin
      state_d = S_SUBRST;
    end else begin
      case (state_q)
        S_SUBRST: begin
          if (sub_cnt_q == SUB_LAST) begin
            state_d    = S_IDLE;
            idle_cnt_d = 4'd0;
            rate_sel_d = bus.rateSelector;
          end else begin
            sub_cnt_d = sub_cnt_q + 3'd1;
          end
        end
        S_IDLE: begin
          if (bit_valid) begin
            if (bit_val == RECESSIVE) begin
              idle_cnt_d = (idle_cnt_q == IDLE_N) ? idle_cnt_q : idle_cnt_q + 4'd1;
              if (idle_cnt_d == IDLE_N) state_d = S_ARMED;
            end else begin
              idle_cnt_d = 4'd0;
            end
          end
        end
        S_ARMED: begin
          if (bit_valid && bit_val == DOMINANT) begin
            state_d    = S_HEADER;
            hdr_cnt_d  = 6'd1;
            run_len_d  = 3'd1;
            prev_bit_d = DOMINANT;
          end
        end
        S_HEADER: begin
          if (bit_valid) begin
            run_len_d  = run_nxt;
            prev_bit_d = bit_val;
          end
          if (counted) hdr_cnt_d = hdr_cnt_q + 6'd1;
          if (stuff_viol) begin
            serr_d  = 1'b1;
            state_d = S_SUBRST;
          end else if (bus.sdComplete) begin
            dlc_d      = bus.sdMsgSize;
            body_tgt_d = body_target(bus.sdMsgSize, MAX_DATA_BYTES, CRC_BITS);
            body_cnt_d = 7'd0;
            state_d    = S_BODY;
          end else if (counted && hdr_cnt_d == HDR_N) begin
            tmo_d   = 1'b1;
            state_d = S_SUBRST;
          end
        end
        S_BODY: begin
          if (bit_valid) begin
            run_len_d  = run_nxt;
            prev_bit_d = bit_val;
          end
          if (stuff_viol) begin
            serr_d  = 1'b1;
            state_d = S_SUBRST;
          end else if (counted) begin
            body_cnt_d = body_cnt_q + 7'd1;
            if (body_cnt_d == body_tgt_q) begin
              tail_cnt_d = 4'd0;
              state_d    = S_TAIL;
            end
          end
        end
        S_TAIL: begin
          if (bit_valid) begin
            tail_cnt_d = tail_cnt_q + 4'd1;
            if (tail_cnt_d == TAIL_N) begin
              done_d  = 1'b1;
              state_d = S_SUBRST;
            end
          end
        end
        default: state_d = S_SUBRST;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_SUBRST;
      sub_cnt_q  <= 3'd0;
      idle_cnt_q <= 4'd0;
      hdr_cnt_q  <= 6'd0;
      body_cnt_q <= 7'd0;
      body_tgt_q <= 7'd0;
      tail_cnt_q <= 4'd0;
      run_len_q  <= 3'd0;
      prev_bit_q <= RECESSIVE;
      rate_sel_q <= 1'b0;
      dlc_q      <= 4'd0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_cnt_q  <= sub_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      hdr_cnt_q  <= hdr_cnt_d;
      body_cnt_q <= body_cnt_d;
      body_tgt_q <= body_tgt_d;
      tail_cnt_q <= tail_cnt_d;
      run_len_q  <= run_len_d;
      prev_bit_q <= prev_bit_d;
      rate_sel_q <= rate_sel_d;
      dlc_q      <= dlc_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      serr_q     <= serr_d;
    end
  end

  // Level outputs decode straight from the state so exits clear them at once.
  assign bus.sdResetN    = (state_q != S_SUBRST);
  assign bus.sdEnable    = (state_q == S_ARMED) || (state_q == S_HEADER) || (state_q == S_BODY);
  assign bus.frameActive = (state_q == S_HEADER) || (state_q == S_BODY) || (state_q == S_TAIL);
  assign bus.dlcLatched  = dlc_q;
  assign bus.frameDone   = done_q;
  assign bus.timeoutErr  = tmo_q;
  assign bus.stuffErr    = serr_q;
  assign bus.stateDbg    = state_q;

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Bench for can_frame_sequencer: builds CAN frames as destuffed bit lists,
// stuffs them into wire bits and checks the sequencer's reaction.
module tb_can_frame_sequencer;

  logic clk;
  logic resetN;
  can_frame_sequencer_if bus ();

  can_frame_sequencer dut (.clk(clk), .resetN(resetN), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int tmo_cnt  = 0;
  int serr_cnt = 0;
  bit mode_rs  = 1'b0;
  bit d_q[$];
  bit raw_q[$];
  int hdr_mark;

  always @(negedge clk) begin
    if (bus.frameDone  === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.timeoutErr === 1'b1) tmo_cnt  <= tmo_cnt + 1;
    if (bus.stuffErr   === 1'b1) serr_cnt <= serr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_sample(input bit b);
    bus.dIn = b;
    bus.samplePulse = 1'b1;
    tick();
    bus.samplePulse = 1'b0;
    tick();
  endtask

  task automatic send_bit(input bit b);
    repeat (mode_rs ? 3 : 1) send_sample(b);
  endtask

  // Force a pass through sub-reset so the rate selector is relatched.
  task automatic rearm(input bit rs);
    bus.enable = 1'b0;
    bus.rateSelector = rs;
    tick();
    bus.enable = 1'b1;
    tick();
    tick();
    mode_rs = rs;
  endtask

  task automatic arm(input bit rs);
    rearm(rs);
    repeat (11) send_bit(1'b1);
    check("armed_state", 32'(bus.stateDbg), 32'd2);
  endtask

  task automatic build_header(input int n);
    d_q.delete();
    d_q.push_back(1'b0);
    repeat (n - 1) d_q.push_back(bit'($urandom_range(0, 1)));
  endtask

  // CAN bit stuffing: after five equal wire bits insert the complement,
  // except after the final bit of the stuffed region.
  function automatic void stuff_stream(input int hdr_len);
    int run;
    bit last;
    raw_q.delete();
    run = 0;
    last = 1'b1;
    hdr_mark = -1;
    for (int i = 0; i < d_q.size(); i++) begin
      raw_q.push_back(d_q[i]);
      run = (i > 0 && d_q[i] == last) ? run + 1 : 1;
      last = d_q[i];
      if (i == hdr_len - 1) hdr_mark = raw_q.size() - 1;
      if (run == 5 && i < d_q.size() - 1) begin
        raw_q.push_back(!last);
        last = !last;
        run = 1;
      end
    end
  endfunction

  task automatic give_complete(input int dlc);
    bus.sdMsgSize = 4'(dlc);
    bus.sdComplete = 1'b1;
    tick();
    bus.sdComplete = 1'b0;
    check("dlc_latched", 32'(bus.dlcLatched), 32'(dlc));
    check("body_state", 32'(bus.stateDbg), 32'd4);
  endtask

  task automatic run_frame(input int dlc, input bit zero_pl, input bit tail_dom, input bit rs);
    int tgt, pl, done0, serr0;
    bit b;
    arm(rs);
    pl  = ((dlc > 8) ? 8 : dlc) * 8;
    tgt = pl + 15;
    build_header(19);
    for (int i = 0; i < tgt; i++) d_q.push_back((zero_pl && i < pl) ? 1'b0 : bit'($urandom_range(0, 1)));
    stuff_stream(19);
    done0 = done_cnt;
    serr0 = serr_cnt;
    for (int i = 0; i < raw_q.size(); i++) begin
      send_bit(raw_q[i]);
      if (i == hdr_mark) give_complete(dlc);
    end
    check("body_to_tail", 32'(bus.stateDbg), 32'd5);
    for (int k = 0; k < 10; k++) begin
      b = tail_dom ? (k >= 6) : (k != 1);
      send_bit(b);
      if (k == 8) check("no_early_done", 32'(done_cnt), 32'(done0));
    end
    check("frame_done_pulse", 32'(bus.frameDone), 32'd1);
    check("done_to_subrst", 32'(bus.stateDbg), 32'd0);
    check("done_inactive", 32'(bus.frameActive), 32'd0);
    tick();
    check("done_count", 32'(done_cnt), 32'(done0 + 1));
    check("no_stuff_err", 32'(serr_cnt), 32'(serr0));
  endtask

  initial begin
    int done0, tmo0, serr0;
    resetN = 1'b0;
    bus.enable = 1'b1;
    bus.dIn = 1'b1;
    bus.samplePulse = 1'b0;
    bus.rateSelector = 1'b0;
    bus.sdComplete = 1'b0;
    bus.sdMsgSize = 4'd0;
    tick();
    check("rst_sdResetN", 32'(bus.sdResetN), 32'd0);
    check("rst_sdEnable", 32'(bus.sdEnable), 32'd0);
    check("rst_frameActive", 32'(bus.frameActive), 32'd0);
    check("rst_dlc", 32'(bus.dlcLatched), 32'd0);
    check("rst_pulses", 32'({bus.frameDone, bus.timeoutErr, bus.stuffErr}), 32'd0);
    check("rst_state", 32'(bus.stateDbg), 32'd0);
    resetN = 1'b1;
    tick();
    check("subrst_cyc2", 32'(bus.sdResetN), 32'd0);
    tick();
    check("subrst_to_idle", 32'(bus.stateDbg), 32'd1);

    // Nominal DLC=2 frame, then clamped DLC=15 with all-zero payload.
    run_frame(2, 1'b0, 1'b0, 1'b0);
    run_frame(15, 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) run_frame($urandom_range(0, 15), 1'b0, 1'b0, bit'($urandom_range(0, 1)));
    // Six dominant wire bits in the tail are EOF territory, not a stuff error.
    run_frame(3, 1'b0, 1'b1, 1'b0);

    // Header timeout: sdComplete never arrives.
    arm(1'b0);
    build_header(40);
    stuff_stream(40);
    tmo0 = tmo_cnt;
    for (int i = 0; i < raw_q.size() - 1; i++) send_bit(raw_q[i]);
    check("tmo_not_yet", 32'(bus.stateDbg), 32'd3);
    check("tmo_no_pulse_yet", 32'(tmo_cnt), 32'(tmo0));
    send_bit(raw_q[raw_q.size() - 1]);
    check("tmo_pulse", 32'(bus.timeoutErr), 32'd1);
    check("tmo_inactive", 32'(bus.frameActive), 32'd0);
    check("tmo_sdreset_1", 32'(bus.sdResetN), 32'd0);
    tick();
    check("tmo_sdreset_2", 32'(bus.sdResetN), 32'd0);
    tick();
    check("tmo_idle", 32'(bus.stateDbg), 32'd1);
    check("tmo_sdreset_rel", 32'(bus.sdResetN), 32'd1);

    // Six dominant bits inside the body.
    arm(1'b0);
    build_header(19);
    d_q.push_back(1'b0);
    d_q.push_back(1'b1);
    repeat (5) d_q.push_back(1'b0);
    stuff_stream(19);
    serr0 = serr_cnt;
    for (int i = 0; i < raw_q.size(); i++) begin
      send_bit(raw_q[i]);
      if (i == hdr_mark) give_complete(2);
    end
    check("serr_not_yet", 32'(serr_cnt), 32'(serr0));
    send_bit(1'b0);
    check("serr_pulse", 32'(bus.stuffErr), 32'd1);
    check("serr_subrst", 32'(bus.stateDbg), 32'd0);
    check("serr_inactive", 32'(bus.frameActive), 32'd0);

    // Enable dropped in the body.
    arm(1'b0);
    build_header(19);
    stuff_stream(19);
    for (int i = 0; i < raw_q.size(); i++) send_bit(raw_q[i]);
    give_complete(3);
    send_bit(1'b1);
    done0 = done_cnt; tmo0 = tmo_cnt; serr0 = serr_cnt;
    bus.enable = 1'b0;
    tick();
    check("en_subrst", 32'(bus.stateDbg), 32'd0);
    check("en_inactive", 32'(bus.frameActive), 32'd0);
    check("en_sdEnable", 32'(bus.sdEnable), 32'd0);
    tick();
    tick();
    check("en_hold", 32'(bus.stateDbg), 32'd0);
    check("en_no_pulses", 32'(done_cnt + tmo_cnt + serr_cnt), 32'(done0 + tmo0 + serr0));
    check("en_dlc_held", 32'(bus.dlcLatched), 32'd3);
    bus.enable = 1'b1;

    // Three-sample voting: 1,0,1 votes recessive, 0,1,0 votes dominant.
    rearm(1'b1);
    for (int k = 0; k < 11; k++) begin
      send_sample(1'b1);
      send_sample(1'b0);
      send_sample(1'b1);
      if (k == 9) check("vote_idle_after10", 32'(bus.stateDbg), 32'd1);
    end
    check("vote_101_armed", 32'(bus.stateDbg), 32'd2);
    send_sample(1'b0);
    send_sample(1'b1);
    check("vote_partial", 32'(bus.stateDbg), 32'd2);
    send_sample(1'b0);
    check("vote_010_sof", 32'(bus.stateDbg), 32'd3);
    check("vote_active", 32'(bus.frameActive), 32'd1);

    // Asynchronous reset in the middle of the header.
    send_sample(1'b1);
    #2;
    resetN = 1'b0;
    #1;
    check("arst_state", 32'(bus.stateDbg), 32'd0);
    check("arst_outputs", 32'({bus.sdResetN, bus.sdEnable, bus.frameActive}), 32'd0);
    check("arst_dlc", 32'(bus.dlcLatched), 32'd0);
    check("arst_pulses", 32'({bus.frameDone, bus.timeoutErr, bus.stuffErr}), 32'd0);
    tick();
    bus.rateSelector = 1'b0;
    mode_rs = 1'b0;
    resetN = 1'b1;
    tick();
    tick();
    check("arst_recover_idle", 32'(bus.stateDbg), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
